// File: rtl/is_ctrl_pkg.sv
// Shared types, widths and opcode constants for the issue-stage controller.
// Provides the FSM state encoding and opcode classification helpers.
package is_ctrl_pkg;

    localparam int REG_DAT_W = 32;
    localparam int INS_DAT_W = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OPC_LOAD) || (op == OPC_STORE);
    endfunction

endpackage

// File: rtl/is_fifo.sv
// DEPTH x W circular buffer holding fetched {pc, ins} pairs.
// Ports: push_i/din_i write, pop_i read, clr_i empties; count_o, full_o, head_o.
module is_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clr_i,
    input  logic [W-1:0]               din_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic [W-1:0]               head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + AW'(1);
            if (pop_i)  rd_d = rd_q + AW'(1);
            unique case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_q] <= din_i;
    end

    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/is_ctrl.sv
// Issue-stage controller: buffers fetched ops, issues one per cycle with
// in-order ROB tags, drops illegal opcodes and recovers from mispredict flush.
module is_ctrl
    import is_ctrl_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iIF_En,
    input  logic [REG_DAT_W-1:0] iIF_Pc,
    input  logic [INS_DAT_W-1:0] iIF_Ins,
    output logic                 oIF_Full,
    input  logic                 iROB_Full,
    input  logic                 iRS_Full,
    input  logic                 iLSB_Full,
    input  logic                 iROB_Clear,
    output logic                 oIS_En,
    output logic [REG_DAT_W-1:0] oIS_Pc,
    output logic [INS_DAT_W-1:0] oIS_Ins,
    output logic                 oIS_Mem,
    output logic [TAG_W-1:0]     oIS_Tag,
    output logic                 oIS_Drop
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_e         state_q, state_d;
    logic [FW-1:0]  fcnt_q, fcnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic                 en_q, en_d;
    logic                 drop_q, drop_d;
    logic                 mem_q, mem_d;
    logic [REG_DAT_W-1:0] pc_q, pc_d;
    logic [INS_DAT_W-1:0] ins_q, ins_d;
    logic [TAG_W-1:0]     otag_q, otag_d;

    logic [CW-1:0] cnt;
    logic          ff_full;
    logic [REG_DAT_W+INS_DAT_W-1:0] head;

    logic clr, go, legal, mem, room;
    logic issue, drop, push, pop;

    // Clear outranks everything; the head is never considered in FLUSH.
    assign clr      = en && iROB_Clear;
    assign oIF_Full = ff_full || (state_q == S_FLUSH);
    assign go       = en && (cnt != '0) && (state_q != S_FLUSH) && !clr;
    assign legal    = is_legal(head[6:0]);
    assign mem      = is_mem(head[6:0]);
    assign room     = !iROB_Full && (mem ? !iLSB_Full : !iRS_Full);
    assign issue    = go && legal && room;
    assign drop     = go && !legal;
    assign push     = en && iIF_En && !oIF_Full && !clr;
    assign pop      = issue || drop;

    is_fifo #(
        .DEPTH (DEPTH),
        .W     (REG_DAT_W + INS_DAT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clr_i   (clr),
        .din_i   ({iIF_Pc, iIF_Ins}),
        .count_o (cnt),
        .full_o  (ff_full),
        .head_o  (head)
    );

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (clr) begin
            state_d = S_FLUSH;
            fcnt_d  = FW'(FLUSH_CYC - 1);
        end else if (en) begin
            unique case (state_q)
                S_RUN: begin
                    if (go && legal && !room) state_d = S_STALL;
                end
                S_STALL: begin
                    if (issue) state_d = S_RUN;
                end
                S_FLUSH: begin
                    if (fcnt_q == '0) state_d = S_RUN;
                    else fcnt_d = fcnt_q - FW'(1);
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_comb begin
        tag_d  = tag_q;
        en_d   = issue;
        drop_d = drop;
        mem_d  = mem_q;
        pc_d   = pc_q;
        ins_d  = ins_q;
        otag_d = otag_q;
        if (clr) begin
            tag_d = '0;
        end else if (issue) begin
            tag_d  = tag_q + TAG_W'(1);
            mem_d  = mem;
            pc_d   = head[REG_DAT_W+INS_DAT_W-1:INS_DAT_W];
            ins_d  = head[INS_DAT_W-1:0];
            otag_d = tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            fcnt_q  <= '0;
            tag_q   <= '0;
            en_q    <= 1'b0;
            drop_q  <= 1'b0;
            mem_q   <= 1'b0;
            pc_q    <= '0;
            ins_q   <= '0;
            otag_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            tag_q   <= tag_d;
            en_q    <= en_d;
            drop_q  <= drop_d;
            mem_q   <= mem_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            otag_q  <= otag_d;
        end
    end

    assign oIS_En   = en_q;
    assign oIS_Drop = drop_q;
    assign oIS_Mem  = mem_q;
    assign oIS_Pc   = pc_q;
    assign oIS_Ins  = ins_q;
    assign oIS_Tag  = otag_q;

endmodule

// File: tb/tb_is_ctrl.sv
// Directed testbench for is_ctrl: issue, stall, LSB routing, illegal drop,
// flush recovery, tag wrap and asynchronous reset.
module tb_is_ctrl;
    import is_ctrl_pkg::*;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0000A103;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        iIF_En = 1'b0;
    logic [31:0] iIF_Pc = '0;
    logic [31:0] iIF_Ins = '0;
    logic        oIF_Full;
    logic        iROB_Full = 1'b0;
    logic        iRS_Full = 1'b0;
    logic        iLSB_Full = 1'b0;
    logic        iROB_Clear = 1'b0;
    logic        oIS_En;
    logic [31:0] oIS_Pc;
    logic [31:0] oIS_Ins;
    logic        oIS_Mem;
    logic [3:0]  oIS_Tag;
    logic        oIS_Drop;

    int cmp = 0;
    int bad = 0;
    logic [38:0] obs, exp;

    always #5 clk = ~clk;

    is_ctrl #(.DEPTH(4), .TAG_W(4), .FLUSH_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .iIF_En     (iIF_En),
        .iIF_Pc     (iIF_Pc),
        .iIF_Ins    (iIF_Ins),
        .oIF_Full   (oIF_Full),
        .iROB_Full  (iROB_Full),
        .iRS_Full   (iRS_Full),
        .iLSB_Full  (iLSB_Full),
        .iROB_Clear (iROB_Clear),
        .oIS_En     (oIS_En),
        .oIS_Pc     (oIS_Pc),
        .oIS_Ins    (oIS_Ins),
        .oIS_Mem    (oIS_Mem),
        .oIS_Tag    (oIS_Tag),
        .oIS_Drop   (oIS_Drop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        iIF_En = 1'b0;
        iRS_Full = 1'b0;
        iLSB_Full = 1'b0;
        iROB_Full = 1'b0;
        iROB_Clear = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        obs = {oIS_En, oIS_Drop, oIS_Mem, oIS_Tag, oIS_Pc};
        exp = '0;
        cmp++;
        if (obs !== exp || oIS_Ins !== 32'h0 || oIF_Full !== 1'b0) begin
            bad++;
            $display("FAIL reset got=%h full=%b exp=%h full=0", obs, oIF_Full, exp);
        end
        step();
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        iIF_En = 1'b1; iIF_Pc = 32'h0; iIF_Ins = ADDI;
        step();
        iIF_En = 1'b0;
        cmp++;
        if (oIS_En !== 1'b0) begin
            bad++;
            $display("FAIL no_bypass got=%b exp=0", oIS_En);
        end
        step();
        obs = {oIS_En, oIS_Drop, oIS_Mem, oIS_Tag, oIS_Pc};
        exp = {1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
        cmp++;
        if (obs !== exp || oIS_Ins !== ADDI) begin
            bad++;
            $display("FAIL single0 got=%h ins=%h exp=%h", obs, oIS_Ins, exp);
        end
        iIF_En = 1'b1; iIF_Pc = 32'h4; iIF_Ins = 32'h00100113;
        step();
        iIF_En = 1'b0;
        step();
        obs = {oIS_En, oIS_Drop, oIS_Mem, oIS_Tag, oIS_Pc};
        exp = {1'b1, 1'b0, 1'b0, 4'd1, 32'h4};
        cmp++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL single1 got=%h exp=%h", obs, exp);
        end
        step();
        obs = {oIS_En, oIS_Drop, oIS_Mem, oIS_Tag, oIS_Pc};
        exp = {1'b0, 1'b0, 1'b0, 4'd1, 32'h4};
        cmp++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL strobe_hold got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_stall();
        do_reset();
        iRS_Full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            iIF_En = 1'b1; iIF_Pc = 32'h100 + 32'(4 * i); iIF_Ins = ADDI;
            step();
        end
        iIF_En = 1'b0;
        cmp++;
        if (oIF_Full !== 1'b1 || oIS_En !== 1'b0 || dut.state_q !== S_STALL) begin
            bad++;
            $display("FAIL stall_full got full=%b en=%b st=%0d exp full=1 en=0 st=1",
                     oIF_Full, oIS_En, dut.state_q);
        end
        iRS_Full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            obs = {oIS_En, oIS_Drop, oIS_Mem, oIS_Tag, oIS_Pc};
            exp = {1'b1, 1'b0, 1'b0, 4'(i), 32'h100 + 32'(4 * i)};
            cmp++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL stall_issue%0d got=%h exp=%h", i, obs, exp);
            end
        end
        step();
        cmp++;
        if (oIS_En !== 1'b0 || oIF_Full !== 1'b0) begin
            bad++;
            $display("FAIL fifth_ignored got en=%b full=%b exp en=0 full=0",
                     oIS_En, oIF_Full);
        end
    endtask

    task automatic test_mem();
        do_reset();
        iLSB_Full = 1'b1;
        iIF_En = 1'b1; iIF_Pc = 32'h200; iIF_Ins = LW;
        step();
        iIF_En = 1'b0;
        step();
        step();
        cmp++;
        if (oIS_En !== 1'b0) begin
            bad++;
            $display("FAIL lsb_block got=%b exp=0", oIS_En);
        end
        iLSB_Full = 1'b0;
        iRS_Full = 1'b1;
        step();
        obs = {oIS_En, oIS_Drop, oIS_Mem, oIS_Tag, oIS_Pc};
        exp = {1'b1, 1'b0, 1'b1, 4'd0, 32'h200};
        cmp++;
        if (obs !== exp || oIS_Ins !== LW) begin
            bad++;
            $display("FAIL lsb_issue got=%h ins=%h exp=%h", obs, oIS_Ins, exp);
        end
        iRS_Full = 1'b0;
    endtask

    task automatic test_drop();
        do_reset();
        iIF_En = 1'b1; iIF_Pc = 32'h300; iIF_Ins = 32'hFFFFFFFF;
        step();
        iIF_Pc = 32'h304; iIF_Ins = ADDI;
        step();
        iIF_En = 1'b0;
        cmp++;
        if (oIS_Drop !== 1'b1 || oIS_En !== 1'b0) begin
            bad++;
            $display("FAIL drop got drop=%b en=%b exp drop=1 en=0", oIS_Drop, oIS_En);
        end
        step();
        obs = {oIS_En, oIS_Drop, oIS_Mem, oIS_Tag, oIS_Pc};
        exp = {1'b1, 1'b0, 1'b0, 4'd0, 32'h304};
        cmp++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL after_drop got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_flush();
        do_reset();
        iIF_En = 1'b1; iIF_Pc = 32'h400; iIF_Ins = ADDI;
        step();
        iIF_En = 1'b0;
        step();
        iRS_Full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iIF_En = 1'b1; iIF_Pc = 32'h410 + 32'(4 * i);
            step();
        end
        iIF_Pc = 32'h41C;
        iROB_Clear = 1'b1;
        step();
        iROB_Clear = 1'b0;
        iRS_Full = 1'b0;
        iIF_Pc = 32'h600;
        cmp++;
        if (oIF_Full !== 1'b1 || oIS_En !== 1'b0 || oIS_Drop !== 1'b0) begin
            bad++;
            $display("FAIL flush0 got full=%b en=%b exp full=1 en=0", oIF_Full, oIS_En);
        end
        step();
        iIF_En = 1'b0;
        cmp++;
        if (oIF_Full !== 1'b1 || oIS_En !== 1'b0) begin
            bad++;
            $display("FAIL flush1 got full=%b en=%b exp full=1 en=0", oIF_Full, oIS_En);
        end
        step();
        cmp++;
        if (oIF_Full !== 1'b0 || oIS_En !== 1'b0) begin
            bad++;
            $display("FAIL flush_exit got full=%b en=%b exp full=0 en=0", oIF_Full, oIS_En);
        end
        step();
        cmp++;
        if (oIS_En !== 1'b0) begin
            bad++;
            $display("FAIL flush_empty got=%b exp=0", oIS_En);
        end
        iIF_En = 1'b1; iIF_Pc = 32'h500;
        step();
        iIF_En = 1'b0;
        step();
        obs = {oIS_En, oIS_Drop, oIS_Mem, oIS_Tag, oIS_Pc};
        exp = {1'b1, 1'b0, 1'b0, 4'd0, 32'h500};
        cmp++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL flush_tag got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            iIF_En = 1'b1; iIF_Pc = 32'(4 * i); iIF_Ins = ADDI;
            step();
            if (i > 0) begin
                obs = {oIS_En, oIS_Drop, oIS_Mem, oIS_Tag, oIS_Pc};
                exp = {1'b1, 1'b0, 1'b0, 4'(i - 1), 32'(4 * (i - 1))};
                cmp++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL b2b%0d got=%h exp=%h", i - 1, obs, exp);
                end
            end
        end
        iIF_En = 1'b0;
        step();
        obs = {oIS_En, oIS_Drop, oIS_Mem, oIS_Tag, oIS_Pc};
        exp = {1'b1, 1'b0, 1'b0, 4'd0, 32'h40};
        cmp++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL tag_wrap got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_async_reset();
        iRS_Full = 1'b1;
        iIF_En = 1'b1; iIF_Pc = 32'h700; iIF_Ins = ADDI;
        step();
        iIF_Pc = 32'h704;
        step();
        iIF_En = 1'b0;
        rst = 1'b0;
        #1;
        obs = {oIS_En, oIS_Drop, oIS_Mem, oIS_Tag, oIS_Pc};
        exp = '0;
        cmp++;
        if (obs !== exp || oIS_Ins !== 32'h0 || oIF_Full !== 1'b0) begin
            bad++;
            $display("FAIL async_rst got=%h ins=%h full=%b exp=0", obs, oIS_Ins, oIF_Full);
        end
        step();
        rst = 1'b1;
        iRS_Full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp++;
            if (oIS_En !== 1'b0 || oIS_Drop !== 1'b0) begin
                bad++;
                $display("FAIL rst_discard%0d got en=%b drop=%b exp 0", i, oIS_En, oIS_Drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_mem();
        test_drop();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
